// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the sequential binary-to-BCD
//               converter (bin2bcd_seq) and its digit-adjust cell.
//               Contents: FSM state enum, BCD digit width, add-3 threshold
//               and adjustment value used by double dabble.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ     = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Combinational double-dabble digit correction. Adds 3 to a
//               BCD digit that is 5 or more, so that the following left
//               shift carries correctly into the next decimal digit.
// Ports       : digit_in  [3:0] - BCD digit before correction
//               digit_out [3:0] - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= ADD3_THRESH) ? (digit_in + BCD_ADJ) : digit_in;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Handshaked sequential binary-to-BCD converter (double dabble).
//               Converts a BIN_W-bit unsigned or two's-complement value into
//               DIGITS packed BCD digits plus sign and overflow flags.
//               One ADD and one SHIFT cycle per input bit.
// Parameters  : BIN_W  - input width (>= 4)
//               DIGITS - number of BCD output digits (>= 1)
//               SIGNED - 1: bin_in is two's complement, 0: unsigned
// Ports       : clk, rst_n (async, active-low)
//               start/bin_in  - request, accepted while in_ready=1
//               in_ready      - high only when idle
//               out_valid     - one-cycle pulse when results update
//               bcd_out       - packed BCD, digit 0 in [3:0]
//               neg_out       - result negative
//               ovf_out       - magnitude >= 10^DIGITS, bcd_out truncated
//               blank_out     - leading-zero blank mask
// Options     : BIN2BCD_BLANK_EN - when defined, blank_out is driven with the
//               leading-zero mask; otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4,
  parameter int SIGNED = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BIN_W-1:0]            bin_in,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                        neg_out,
  output logic                        ovf_out,
  output logic [DIGITS-1:0]           blank_out
);

  localparam int                BCD_W    = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W    = $clog2(BIN_W);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               ovf_int_q, ovf_int_d;
  logic               out_valid_q, out_valid_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_out_q, ovf_out_d;

  logic [BCD_W-1:0]   w_adj_digits;
  logic               w_neg_in;

  // Zero has a clear MSB, so it is never flagged negative.
  assign w_neg_in = (SIGNED != 0) && bin_in[BIN_W-1];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
    bcd_digit_adj u_adj (
      .digit_in  (digits_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (w_adj_digits[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    digits_d    = digits_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    ovf_int_d   = ovf_int_q;
    out_valid_d = 1'b0;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    ovf_out_d   = ovf_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Two's-complement negation in BIN_W bits; the most-negative input
          // maps to 2^(BIN_W-1), which is the correct unsigned magnitude.
          mag_d     = w_neg_in ? (BIN_W'(0) - bin_in) : bin_in;
          sign_d    = w_neg_in;
          digits_d  = '0;
          ovf_int_d = 1'b0;
          cnt_d     = CNT_LOAD;
          state_d   = ADD;
        end
      end
      ADD: begin
        digits_d = w_adj_digits;
        state_d  = SHIFT;
      end
      SHIFT: begin
        {digits_d, mag_d} = {digits_q[BCD_W-2:0], mag_q, 1'b0};
        // A one leaving the top digit means the value reached 10^DIGITS;
        // the remaining digits keep the value modulo 10^DIGITS.
        ovf_int_d = ovf_int_q | digits_q[BCD_W-1];
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        bcd_d       = digits_q;
        neg_d       = sign_q;
        ovf_out_d   = ovf_int_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      digits_q    <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      ovf_int_q   <= 1'b0;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      ovf_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      digits_q    <= digits_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      ovf_int_q   <= ovf_int_d;
      out_valid_q <= out_valid_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_above;

  // Walk from the top digit down: a digit is blanked while it and every
  // digit above it are zero. Digit 0 is always shown; overflow shows all.
  always_comb begin
    w_zero_above = 1'b1;
    w_blank      = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_zero_above = w_zero_above && (digits_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      w_blank[i]   = w_zero_above && !ovf_int_q;
    end
  end

  always_comb begin
    blank_d = blank_q;
    if (state_q == DONE) begin
      blank_d = w_blank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank_out = blank_q;
`else
  assign blank_out = '0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign neg_out   = neg_q;
  assign ovf_out   = ovf_out_q;

endmodule : bin2bcd_seq
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq. Two instances: the
//               default configuration (12 bits, 4 digits, signed) and a
//               12-bit, 3-digit unsigned one for overflow behaviour.
//               Expected values come from a decimal arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_a = 1'b0;
  logic [11:0] bin_a   = '0;
  logic        in_ready_a, out_valid_a, neg_a, ovf_a;
  logic [15:0] bcd_a;
  logic [3:0]  blank_a;

  logic        start_b = 1'b0;
  logic [11:0] bin_b   = '0;
  logic        in_ready_b, out_valid_b, neg_b, ovf_b;
  logic [11:0] bcd_b;
  logic [2:0]  blank_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .bcd_out(bcd_a),
    .neg_out(neg_a), .ovf_out(ovf_a), .blank_out(blank_a)
  );

  bin2bcd_seq #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .bcd_out(bcd_b),
    .neg_out(neg_b), .ovf_out(ovf_b), .blank_out(blank_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: magnitude from the signed interpretation, digits by
  // repeated division, overflow and blanking by comparing against 10^k.
  function automatic void model(input longint v, input int w, input int d, input bit sgn,
                                output logic [15:0] bcd, output logic neg,
                                output logic ovf, output logic [3:0] blank);
    longint mag, p, t;
    mag = v;
    neg = 1'b0;
    if (sgn && v >= (longint'(1) << (w - 1))) begin
      mag = (longint'(1) << w) - v;
      neg = 1'b1;
    end
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    ovf = (mag >= p);
    bcd = '0;
    t   = mag;
    for (int i = 0; i < d; i++) begin
      bcd[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    blank = '0;
`ifdef BIN2BCD_BLANK_EN
    p = 1;
    for (int i = 1; i < d; i++) begin
      p = p * 10;
      blank[i] = !ovf && (mag < p);
    end
`endif
  endfunction

  task automatic conv_a(input logic [11:0] v);
    logic [15:0] eb; logic en, eo; logic [3:0] ebl; int cyc;
    model(longint'(v), 12, 4, 1'b1, eb, en, eo, ebl);
    @(negedge clk);
    check("a_in_ready_idle", 32'(in_ready_a), 32'd1);
    start_a = 1'b1;
    bin_a   = v;
    @(posedge clk); #1;
    start_a = 1'b0;
    bin_a   = 12'($urandom);
    cyc = 0;
    while (out_valid_a !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("a_latency", 32'(cyc), 32'd25);
    check("a_bcd", 32'(bcd_a), 32'(eb));
    check("a_neg", 32'(neg_a), 32'(en));
    check("a_ovf", 32'(ovf_a), 32'(eo));
    check("a_blank", 32'(blank_a), 32'(ebl));
    check("a_ready_with_valid", 32'(in_ready_a), 32'd1);
    @(posedge clk); #1;
    check("a_valid_pulse", 32'(out_valid_a), 32'd0);
    check("a_hold", 32'(bcd_a), 32'(eb));
  endtask

  task automatic conv_b(input logic [11:0] v);
    logic [15:0] eb; logic en, eo; logic [3:0] ebl; int cyc;
    model(longint'(v), 12, 3, 1'b0, eb, en, eo, ebl);
    @(negedge clk);
    start_b = 1'b1;
    bin_b   = v;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 0;
    while (out_valid_b !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b_latency", 32'(cyc), 32'd25);
    check("b_bcd", 32'(bcd_b), 32'(eb[11:0]));
    check("b_neg", 32'(neg_b), 32'd0);
    check("b_ovf", 32'(ovf_b), 32'(eo));
    check("b_blank", 32'(blank_b), 32'(ebl[2:0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] q[$];
    logic [11:0] v;
    logic [15:0] eb; logic en, eo; logic [3:0] ebl;
    int last, pulses, cyc, nvalid;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready_a), 32'd1);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'd0);
    check("rst_neg", 32'(neg_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_blank", 32'(blank_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values
    conv_a(12'h000);
    conv_a(12'h7FF);
    conv_a(12'h800);
    conv_a(12'hFFF);
    conv_a(12'd42);
    conv_a(12'd1234);
    conv_b(12'd4095);
    conv_b(12'd999);
    conv_b(12'd1000);
    conv_b(12'd0);

    // Random values
    for (int i = 0; i < 20; i++) conv_a(12'($urandom));
    for (int i = 0; i < 10; i++) conv_b(12'($urandom));

    // start held high: only the idle cycles accept, one result every 26 cycles
    last   = -1;
    pulses = 0;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = 12'($urandom);
      if (in_ready_a) q.push_back(bin_a);
      @(posedge clk); #1;
      if (out_valid_a) begin
        if (last >= 0) check("b2b_gap", 32'(c - last), 32'd26);
        last = c;
        pulses++;
        if (q.size() == 0) begin
          check("b2b_unexpected_valid", 32'd1, 32'd0);
        end else begin
          v = q.pop_front();
          model(longint'(v), 12, 4, 1'b1, eb, en, eo, ebl);
          check("b2b_bcd", 32'(bcd_a), 32'(eb));
          check("b2b_neg", 32'(neg_a), 32'(en));
        end
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd5);
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (q.size() > 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid_a) begin
        v = q.pop_front();
        model(longint'(v), 12, 4, 1'b1, eb, en, eo, ebl);
        check("b2b_drain_bcd", 32'(bcd_a), 32'(eb));
      end
    end
    check("b2b_drained", 32'(q.size()), 32'd0);

    // Reset in the middle of a conversion
    conv_a(12'd999);
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 12'($urandom);
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready_a), 32'd1);
    check("mid_rst_valid", 32'(out_valid_a), 32'd0);
    check("mid_rst_bcd", 32'(bcd_a), 32'd0);
    check("mid_rst_neg", 32'(neg_a), 32'd0);
    check("mid_rst_ovf", 32'(ovf_a), 32'd0);
    check("mid_rst_blank", 32'(blank_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid_a) nvalid++;
    end
    check("mid_rst_no_valid", 32'(nvalid), 32'd0);
    conv_a(12'd1234);
    check("post_rst_1234", 32'(bcd_a), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bin2bcd_seq
`default_nettype wire
